countdown_round_controller: RTL
===============================

// Module: countdown_round_controller
// PURPOSE
//  Initiator-side controller for the random countdown timer. Issues a 1-cycle trigger to start a round
//  and watches the returned count; a player hit before count reaches 0 scores, otherwise the round expires.
//  Sits between the debounced pushbuttons and the timer; it feeds score/result to the display logic.
// PARAMETERS
//  START_TIMEOUT   8            cycles after trigger to wait for count!=0 before declaring expiry
//  RESULT_HOLD     100_000_000  cycles the HIT/EXPIRED result is held before returning to IDLE (1 s @100 MHz)
//  SCORE_W         4            score width; score saturates at 2**SCORE_W-1
// PORTS
//  clk            in   1        system clock, 100 MHz
//  reset          in   1        synchronous, active-high reset
//  start_btn      in   1        debounced level; its rising edge starts a round
//  player_hit     in   1        debounced level; its rising edge is the player's response
//  count          in   5        remaining seconds from the countdown timer (0 when the timer is idle)
//  trigger        out  1        1-cycle start pulse to the countdown timer
//  round_active   out  1        high in ARM, WAIT_START and RUNNING
//  hit            out  1        high while in HIT
//  expired        out  1        high while in EXPIRED
//  score          out  SCORE_W  successful-round count, saturating
//  hit_remaining  out  5        count value captured on the cycle of the scoring hit
// BEHAVIOUR
//  - Interface: one clock (clk); reset is synchronous and active-high (reset).
//  - Reset (any state, including mid-round): state=IDLE; trigger, round_active, hit and expired =0;
//    score=0; hit_remaining=0; edge-detect history=0; all counters=0.
//  - Edges: rise = in & ~in_q, with in_q registered. Only rising edges act; held levels are ignored.
//  - IDLE: start rise -> ARM. Player rises in IDLE are ignored.
//  - ARM: trigger=1 for exactly this one cycle -> WAIT_START, wait counter cleared.
//  - WAIT_START: count!=0 -> RUNNING. Otherwise the wait counter increments.
//    If the counter reaches START_TIMEOUT-1 with count still 0, go to EXPIRED.
//    This covers a timer that loaded 0. A player rise in this state is ignored.
//  - RUNNING:
//    - player rise with count!=0 -> HIT; hit_remaining<=count; score<=score+1 (held at max).
//    - count==0 -> EXPIRED. A player rise in the same cycle does not score; expiry wins.
//  - HIT / EXPIRED: hold counter runs. At RESULT_HOLD-1 -> IDLE.
//    A start rise during the hold is ignored and is not queued.
//  - Outputs are registered and decoded from the state register.
//  - trigger is registered and fires the cycle after the start rise is detected.
//  - hit_remaining keeps its value until the next scoring hit or reset.
//  - Counters are ceil(log2(param)) wide. None of them wraps; each is cleared on state entry.
// CONFIGURATION
//  Macro ROUND_LED_BAR_EN:
//  - Defined: adds output led[15:0], a registered thermometer of count during RUNNING
//    (bits [count-1:0] set; count>=16 gives all ones). led=0 in all other states and on reset.
//  - Not defined: the led port and its logic are absent.
// STRUCTURE
//  - Package round_ctrl_pkg: 3-bit state encodings IDLE, ARM, WAIT_START, RUNNING, HIT, EXPIRED;
//    COUNT_W=5; LED_W=16.
//  - Sub-module rise_detect (clk, reset, in, rise): two instances, for start_btn and player_hit.
//  - FSM, counters and scoring live in this module.
// TESTING (bench uses RESULT_HOLD=10, START_TIMEOUT=8, simple timer model)
//  1. start rise; model loads 23 -> trigger high exactly 1 cycle; round_active=1.
//     Player rise at count=17 -> hit=1, hit_remaining=17, score=1, IDLE 10 cycles later.
//  2. No player input; count runs 3,2,1,0 -> expired=1 on the cycle after count==0; score unchanged.
//  3. Model loads 0 -> after 8 cycles in WAIT_START expired=1; trigger not re-issued.
//  4. Player rise in the same cycle count becomes 0 -> expired=1, hit=0, score unchanged.
//  5. Score at 15 plus a scoring hit -> score stays 15.
//     reset asserted mid-RUNNING -> next cycle: all outputs 0, state IDLE.
//  6. start_btn held high across 3 rounds' worth of time -> only one trigger.
//     With ROUND_LED_BAR_EN defined, count=5 gives led=16'h001F and count=20 gives 16'hFFFF.

Source files
------------

// File: rtl/round_ctrl_pkg.sv
// rtl/round_ctrl_pkg.sv - state encodings, widths and helpers for the countdown round controller
package round_ctrl_pkg;

  localparam int COUNT_W = 5;
  localparam int LED_W   = 16;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] ARM        = 3'd1;
  localparam logic [2:0] WAIT_START = 3'd2;
  localparam logic [2:0] RUNNING    = 3'd3;
  localparam logic [2:0] HIT        = 3'd4;
  localparam logic [2:0] EXPIRED    = 3'd5;

  // ceil(log2(n)), never narrower than one bit so tiny parameters still elaborate
  function automatic int cnt_w(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

  function automatic logic [LED_W-1:0] therm(input logic [COUNT_W-1:0] c);
    logic [LED_W-1:0] t;
    t = '0;
    for (int i = 0; i < LED_W; i++) t[i] = (COUNT_W'(i) < c);
    return t;
  endfunction

endpackage

// File: rtl/countdown_round_controller_rise_detect.sv
// rtl/countdown_round_controller_rise_detect.sv - registered rising-edge detector for a debounced level
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic in_q;

  always_ff @(posedge clk) begin
    if (reset) in_q <= 1'b0;
    else       in_q <= in;
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/countdown_round_controller.sv
// rtl/countdown_round_controller.sv - round FSM, start timeout, result hold and saturating score
// Macro ROUND_LED_BAR_EN adds the led thermometer output.
module countdown_round_controller
  import round_ctrl_pkg::*;
#(
  parameter int START_TIMEOUT = 8,
  parameter int RESULT_HOLD   = 100_000_000,
  parameter int SCORE_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_btn,
  input  logic               player_hit,
  input  logic [COUNT_W-1:0] count,
  output logic               trigger,
  output logic               round_active,
  output logic               hit,
  output logic               expired,
  output logic [SCORE_W-1:0] score,
  output logic [COUNT_W-1:0] hit_remaining
`ifdef ROUND_LED_BAR_EN
  ,
  output logic [LED_W-1:0]   led
`endif
);

  localparam int WAIT_W = cnt_w(START_TIMEOUT);
  localparam int HOLD_W = cnt_w(RESULT_HOLD);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(START_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESULT_HOLD - 1);

  logic [2:0]        state, state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              start_rise, player_rise;
  logic              count_nz, score_hit, in_result;

  rise_detect u_start_rise (
    .clk   (clk),
    .reset (reset),
    .in    (start_btn),
    .rise  (start_rise)
  );

  rise_detect u_player_rise (
    .clk   (clk),
    .reset (reset),
    .in    (player_hit),
    .rise  (player_rise)
  );

  assign count_nz  = (count != '0);
  assign in_result = (state == HIT) || (state == EXPIRED);
  // expiry takes priority over a simultaneous player press
  assign score_hit = (state == RUNNING) && count_nz && player_rise;

  always_comb begin
    state_d = state;
    case (state)
      IDLE:       if (start_rise) state_d = ARM;
      ARM:        state_d = WAIT_START;
      WAIT_START: begin
        if (count_nz)                   state_d = RUNNING;
        else if (wait_cnt == WAIT_LAST) state_d = EXPIRED;
      end
      RUNNING: begin
        if (!count_nz)        state_d = EXPIRED;
        else if (player_rise) state_d = HIT;
      end
      HIT, EXPIRED: if (hold_cnt == HOLD_LAST) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      hold_cnt      <= '0;
      score         <= '0;
      hit_remaining <= '0;
    end else begin
      state <= state_d;

      if (state != WAIT_START)      wait_cnt <= '0;
      else if (state_d == WAIT_START) wait_cnt <= wait_cnt + 1'b1;

      if (!in_result)           hold_cnt <= '0;
      else if (state_d == state) hold_cnt <= hold_cnt + 1'b1;

      if (score_hit) begin
        hit_remaining <= count;
        if (score != '1) score <= score + 1'b1;
      end
    end
  end

  assign trigger      = (state == ARM);
  assign round_active = (state == ARM) || (state == WAIT_START) || (state == RUNNING);
  assign hit          = (state == HIT);
  assign expired      = (state == EXPIRED);

`ifdef ROUND_LED_BAR_EN
  always_ff @(posedge clk) begin
    if (reset)                   led <= '0;
    else if (state_d == RUNNING) led <= therm(count);
    else                         led <= '0;
  end
`endif

endmodule
